// File: rtl/mmio_bridge_if.sv
// CPU data-port / RAM port-A bus as seen by mmio_bridge.
// The master side is the surrounding system: it drives the CPU request and returns RAM read data.
interface mmio_bridge_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_we;
   logic [DATA_W-1:0] cpu_rdata;
   logic              ram_we;
   logic [DATA_W-1:0] ram_q;

   modport master (
      output cpu_addr, cpu_wdata, cpu_we, ram_q,
      input  cpu_rdata, ram_we
   );

   modport slave (
      input  cpu_addr, cpu_wdata, cpu_we, ram_q,
      output cpu_rdata, ram_we
   );
endinterface

// File: rtl/mmio_bridge.sv
// Memory-mapped I/O bridge: a six-register peripheral window at IO_BASE in front of RAM port A.
// I/O reads are registered so they share the synchronous RAM's one-cycle read latency.
module mmio_bridge #(
   parameter int                DATA_W     = 16,
   parameter int                ADDR_W     = 16,
   parameter logic [ADDR_W-1:0] IO_BASE    = 16'hCFFD,
   parameter int                NUM_SW     = 8,
   parameter int                NUM_DIGITS = 4,
   parameter int                TIMER_W    = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   mmio_bridge_if.slave            bus,
   input  logic [NUM_SW-1:0]       switches,
   output logic [4*NUM_DIGITS-1:0] disp_value,
   output logic                    irq
);
   localparam int DISP_W = 4 * NUM_DIGITS;

   typedef enum logic [2:0] {
      OFF_SW     = 3'd0,
      OFF_DISP   = 3'd1,
      OFF_EDGE   = 3'd2,
      OFF_TIMER  = 3'd3,
      OFF_CMP    = 3'd4,
      OFF_STATUS = 3'd5
   } reg_off_e;

   logic [ADDR_W-1:0]  offset;
   logic               hit;
   logic               wr_disp, wr_edge, wr_timer, wr_cmp, wr_status;

   logic [NUM_SW-1:0]  sw_meta, sw_sync, sw_prev;
   logic [1:0]         arm_cnt;
   logic               armed;
   logic [NUM_SW-1:0]  edge_set, edge_clr, edge_flags;

   logic [TIMER_W-1:0] timer, cmp;
   logic               match, ien_t, ien_e;

   logic [DATA_W-1:0]  io_next, io_q;
   logic               sel_q;

   // Addresses below IO_BASE wrap to large offsets, so one compare covers the whole window.
   assign offset = bus.cpu_addr - IO_BASE;
   assign hit    = (offset < ADDR_W'(6));

   assign wr_disp   = bus.cpu_we & hit & (offset[2:0] == OFF_DISP);
   assign wr_edge   = bus.cpu_we & hit & (offset[2:0] == OFF_EDGE);
   assign wr_timer  = bus.cpu_we & hit & (offset[2:0] == OFF_TIMER);
   assign wr_cmp    = bus.cpu_we & hit & (offset[2:0] == OFF_CMP);
   assign wr_status = bus.cpu_we & hit & (offset[2:0] == OFF_STATUS);

   assign bus.ram_we = bus.cpu_we & ~hit;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sw_meta <= '0;
         sw_sync <= '0;
         sw_prev <= '0;
         arm_cnt <= '0;
      end else begin
         sw_meta <= switches;
         sw_sync <= sw_meta;
         sw_prev <= sw_sync;
         if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
      end
   end

   // Edge detection waits until the synchroniser and prev stage hold real switch samples.
   assign armed    = (arm_cnt == 2'd3);
   assign edge_set = sw_sync & ~sw_prev & {NUM_SW{armed}};
   assign edge_clr = wr_edge ? bus.cpu_wdata[NUM_SW-1:0] : '0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         disp_value <= '0;
         edge_flags <= '0;
         timer      <= '0;
         cmp        <= '0;
         match      <= 1'b0;
         ien_t      <= 1'b0;
         ien_e      <= 1'b0;
         irq        <= 1'b0;
      end else begin
         if (wr_disp) disp_value <= bus.cpu_wdata[DISP_W-1:0];
         if (wr_cmp)  cmp        <= bus.cpu_wdata[TIMER_W-1:0];
         if (wr_status) begin
            ien_t <= bus.cpu_wdata[1];
            ien_e <= bus.cpu_wdata[2];
         end
         // Set is ORed in after the clear so a same-cycle set always survives.
         edge_flags <= (edge_flags & ~edge_clr) | edge_set;
         match      <= (match & ~(wr_status & bus.cpu_wdata[0])) | (timer == cmp);
         timer      <= wr_timer ? bus.cpu_wdata[TIMER_W-1:0] : timer + TIMER_W'(1);
         irq        <= (match & ien_t) | ((|edge_flags) & ien_e);
      end
   end

   always_comb begin
      // NOTE: default first so no path through the case leaves io_next unassigned (no latch).
      io_next = '0;
      case (offset[2:0])
         OFF_SW:     io_next = DATA_W'(sw_sync);
         OFF_DISP:   io_next = DATA_W'(disp_value);
         OFF_EDGE:   io_next = DATA_W'(edge_flags);
         OFF_TIMER:  io_next = DATA_W'(timer);
         OFF_CMP:    io_next = DATA_W'(cmp);
         OFF_STATUS: io_next = DATA_W'({ien_e, ien_t, match});
         default:    io_next = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sel_q <= 1'b0;
         io_q  <= '0;
      end else begin
         sel_q <= hit;
         io_q  <= io_next;
      end
   end

   assign bus.cpu_rdata = sel_q ? io_q : bus.ram_q;
endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: a behavioural RAM on port A and a read-data scoreboard.
// Expected read data is queued at the sampling edge and compared on the following falling edge.
module tb_mmio_bridge;
   localparam logic [15:0] BASE = 16'hCFFD;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  switches;
   logic [15:0] disp_value;
   logic        irq;

   mmio_bridge_if #(.DATA_W(16), .ADDR_W(16)) bus_if ();

   mmio_bridge #(
      .DATA_W(16), .ADDR_W(16), .IO_BASE(BASE),
      .NUM_SW(8), .NUM_DIGITS(4), .TIMER_W(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus_if),
      .switches(switches),
      .disp_value(disp_value),
      .irq(irq)
   );

   always #5 clk = ~clk;

   // Synchronous RAM with one-cycle read latency.
   logic [15:0] mem [0:65535];
   always @(posedge clk) begin
      if (bus_if.ram_we) mem[bus_if.cpu_addr] <= bus_if.cpu_wdata;
      bus_if.ram_q <= mem[bus_if.cpu_addr];
   end

   typedef struct {
      bit          chk;
      string       tag;
      logic [15:0] want;
   } sb_entry_t;

   sb_entry_t sb[$];
   sb_entry_t cur;
   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         cur = sb.pop_front();
         if (cur.chk) check(cur.tag, 32'(bus_if.cpu_rdata), 32'(cur.want));
      end
   end

   function automatic logic ram_target(input logic [15:0] a);
      return (a < BASE) || (a > BASE + 16'd5);
   endfunction

   // One bus cycle: drive, let the edge sample it, queue what cpu_rdata must show afterwards.
   task automatic bus(input logic [15:0] addr, input logic [15:0] wdata, input logic we,
                      input bit chk, input logic [15:0] want, input string tag);
      sb_entry_t e;
      bus_if.cpu_addr  = addr;
      bus_if.cpu_wdata = wdata;
      bus_if.cpu_we    = we;
      if (we) begin
         #1;
         check({tag, "_ram_we"}, 32'(bus_if.ram_we), 32'(ram_target(addr)));
      end
      @(posedge clk);
      e.chk  = chk;
      e.tag  = tag;
      e.want = want;
      sb.push_back(e);
      #1;
   endtask

   task automatic rd(input logic [15:0] addr, input logic [15:0] want, input string tag);
      bus(addr, 16'h0000, 1'b0, 1'b1, want, tag);
   endtask

   task automatic wr(input logic [15:0] addr, input logic [15:0] data, input string tag);
      bus(addr, data, 1'b1, 1'b0, 16'h0000, tag);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) bus(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, "idle");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      reset            = 1'b0;
      switches         = 8'hFF;
      bus_if.cpu_addr  = '0;
      bus_if.cpu_wdata = '0;
      bus_if.cpu_we    = 1'b0;

      // RAM writes pass through while reset is held; cpu_rdata follows ram_q.
      wr(16'h0000, 16'h00A5, "pre0");
      wr(16'h0100, 16'h1234, "pre1");
      rd(16'h0000, 16'h00A5, "rst_rdata");
      check("rst_disp", 32'(disp_value), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);

      // Switches held high through reset must not flag an edge.
      reset = 1'b1;
      idle(10);
      rd(BASE + 16'd2, 16'h0000, "edge_after_rst");
      rd(BASE, 16'h00FF, "sw_after_rst");
      check("irq_after_rst", 32'(irq), 32'h0);

      // DISP register and address decode boundaries.
      wr(BASE + 16'd1, 16'hBEEF, "disp_wr");
      rd(BASE + 16'd1, 16'hBEEF, "disp_rd");
      check("disp_value", 32'(disp_value), 32'hBEEF);
      wr(BASE, 16'hAAAA, "sw_wr");
      rd(BASE, 16'h00FF, "sw_wr_ignored");
      wr(16'hD010, 16'h5555, "ram_d010");
      wr(BASE + 16'd6, 16'h6666, "ram_base6");
      wr(BASE - 16'd1, 16'h7777, "ram_basem1");
      rd(BASE + 16'd6, 16'h6666, "rd_base6");
      rd(16'hD010, 16'h5555, "rd_d010");
      rd(BASE - 16'd1, 16'h7777, "rd_basem1");

      // Edge flag and edge interrupt timing.
      switches = 8'h00;
      idle(4);
      wr(BASE + 16'd2, 16'hFFFF, "edge_clr_all");
      wr(BASE + 16'd5, 16'h0004, "stat_ien_e");
      rd(BASE + 16'd2, 16'h0000, "edge_pre");
      switches = 8'h08;
      idle(2);
      rd(BASE + 16'd2, 16'h0000, "edge_p3");
      check("irq_p3", 32'(irq), 32'h0);
      rd(BASE + 16'd2, 16'h0008, "edge_p4");
      check("irq_p4", 32'(irq), 32'h1);
      wr(BASE + 16'd2, 16'h0008, "edge_clr");
      check("irq_clr_cycle", 32'(irq), 32'h1);
      rd(BASE + 16'd2, 16'h0000, "edge_cleared");
      check("irq_edge_cleared", 32'(irq), 32'h0);

      // A clear landing on the cycle the flag sets leaves it set.
      switches = 8'h18;
      idle(2);
      wr(BASE + 16'd2, 16'h0010, "edge_coll_wr");
      rd(BASE + 16'd2, 16'h0010, "edge_coll");
      wr(BASE + 16'd2, 16'hFFFF, "edge_clr2");
      wr(BASE + 16'd5, 16'h0000, "stat_off");

      // Timer compare, MATCH and timer interrupt.
      wr(BASE + 16'd4, 16'h0010, "cmp_wr");
      rd(BASE + 16'd4, 16'h0010, "cmp_rd");
      wr(BASE + 16'd5, 16'h0003, "stat_t");
      rd(BASE + 16'd5, 16'h0002, "stat_rd");
      check("irq_t_pre", 32'(irq), 32'h0);
      wr(BASE + 16'd3, 16'h000E, "tmr_wr");
      rd(BASE + 16'd5, 16'h0002, "stat_w1");
      rd(BASE + 16'd3, 16'h000F, "tmr_w2");
      rd(BASE + 16'd5, 16'h0002, "stat_w3");
      check("irq_w3", 32'(irq), 32'h0);
      rd(BASE + 16'd5, 16'h0003, "stat_w4");
      check("irq_w4", 32'(irq), 32'h1);
      wr(BASE + 16'd5, 16'h0003, "stat_w1c");
      rd(BASE + 16'd5, 16'h0002, "stat_cleared");
      check("irq_t_clr", 32'(irq), 32'h0);

      // Timer wrap and load-over-increment.
      wr(BASE + 16'd3, 16'hFFFF, "tmr_ffff");
      rd(BASE + 16'd3, 16'hFFFF, "tmr_t1");
      rd(BASE + 16'd3, 16'h0000, "tmr_wrap");
      wr(BASE + 16'd3, 16'h1234, "tmr_load");
      rd(BASE + 16'd3, 16'h1234, "tmr_loaded");
      wr(BASE + 16'd5, 16'h0001, "stat_quiet");

      // Back-to-back alternating RAM and I/O reads.
      for (int i = 0; i < 6; i++) begin
         rd(16'h0100, 16'h1234, "alt_ram");
         rd(BASE, 16'h0018, "alt_sw");
      end

      idle(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
